// File: rtl/df_mon_pkg.sv
// Shared types and helpers for the dataflow process activity/stall monitor.
package df_mon_pkg;

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_RUN    = 2'd1,
    P_OSTALL = 2'd2
  } proc_state_e;

  localparam logic [1:0] RD_ITER  = 2'd0;
  localparam logic [1:0] RD_RUN   = 2'd1;
  localparam logic [1:0] RD_STALL = 2'd2;
  localparam logic [1:0] RD_IDLE  = 2'd3;

  localparam int CNT_MAX_W = 64;

  typedef struct packed {
    logic start;
    logic done;
    logic cont;
  } proc_tap_t;

  // Increment v as a w-bit counter, holding at all-ones instead of wrapping.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v, input int w);
    logic [CNT_MAX_W-1:0] top;
    top = (w >= CNT_MAX_W) ? '1 : ((CNT_MAX_W'(1) << w) - CNT_MAX_W'(1));
    return (v == top) ? v : v + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/df_proc_counter.sv
// One monitored process: ap_ctrl_chain state tracker plus iter/run/stall/idle counters.
module df_proc_counter
  import df_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  proc_tap_t             tap,
  output proc_state_e           state,
  output logic [3:0][CNT_W-1:0] cnt
);

  proc_state_e state_nxt;
  logic [3:0]  inc;

  always_comb begin
    state_nxt = state;
    inc       = '0;
    unique case (state)
      P_IDLE: begin
        if (tap.start) begin
          inc[RD_RUN] = 1'b1;
          if (tap.done && tap.cont) inc[RD_ITER] = 1'b1;
          else if (tap.done)        state_nxt = P_OSTALL;
          else                      state_nxt = P_RUN;
        end else begin
          inc[RD_IDLE] = 1'b1;
        end
      end
      P_RUN: begin
        inc[RD_RUN] = 1'b1;
        if (tap.done) begin
          if (tap.cont) begin
            inc[RD_ITER] = 1'b1;
            state_nxt    = tap.start ? P_RUN : P_IDLE;
          end else begin
            state_nxt = P_OSTALL;
          end
        end
      end
      P_OSTALL: begin
        inc[RD_STALL] = 1'b1;
        if (tap.cont) begin
          inc[RD_ITER] = 1'b1;
          state_nxt    = tap.start ? P_RUN : P_IDLE;
        end
      end
      default: state_nxt = P_IDLE;
    endcase
  end

  // State tracks the handshake even outside the window so counting resumes correctly.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= P_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      for (int k = 0; k < 4; k++)
        if (inc[k]) cnt[k] <= CNT_W'(sat_inc(CNT_MAX_W'(cnt[k]), CNT_W));
    end
  end

endmodule

// File: rtl/df_process_perf_monitor.sv
// Activity/stall monitor for NUM_PROC dataflow processes: window, top counters, deadlock timer, read port.
module df_process_perf_monitor
  import df_mon_pkg::*;
#(
  parameter  int NUM_PROC = 4,
  parameter  int CNT_W    = 32,
  parameter  int TIMEOUT  = 65536,
  localparam int PW       = $clog2(NUM_PROC + 1),
  localparam int TW       = $clog2(TIMEOUT)
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                top_start,
  input  logic                top_done,
  input  logic [NUM_PROC-1:0] p_start,
  input  logic [NUM_PROC-1:0] p_ready,
  input  logic [NUM_PROC-1:0] p_done,
  input  logic [NUM_PROC-1:0] p_continue,
  input  logic                clr,
  input  logic                rd_en,
  input  logic [PW-1:0]       rd_proc,
  input  logic [1:0]          rd_sel,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data,
  output logic                window,
  output logic                deadlock,
  output logic [NUM_PROC-1:0] blocked_mask
);

  logic                                cnt_en;
  logic                                progress;
  logic [NUM_PROC-1:0]                 busy;
  logic [NUM_PROC-1:0][3:0][CNT_W-1:0] pcnt;
  logic [CNT_W-1:0]                    top_iter, top_run, rd_mux;
  logic [TW-1:0]                       timer;

  // The set cycle counts, so the enable looks ahead at top_start.
  assign cnt_en   = window | top_start;
  assign progress = (|p_ready) | (|(p_done & p_continue)) | top_done;

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_proc
    proc_tap_t   tap;
    proc_state_e st;
    assign tap = '{start: p_start[i], done: p_done[i], cont: p_continue[i]};
    df_proc_counter #(.CNT_W(CNT_W)) u_proc (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .en       (cnt_en),
      .clr      (clr),
      .tap      (tap),
      .state    (st),
      .cnt      (pcnt[i])
    );
    assign busy[i] = (st != P_IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) window <= 1'b0;
    else           window <= cnt_en & ~top_done;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      top_iter <= '0;
      top_run  <= '0;
    end else if (clr) begin
      top_iter <= '0;
      top_run  <= '0;
    end else if (cnt_en) begin
      top_run <= CNT_W'(sat_inc(CNT_MAX_W'(top_run), CNT_W));
      if (top_done) top_iter <= CNT_W'(sat_inc(CNT_MAX_W'(top_iter), CNT_W));
    end
  end

  // Timer parks at TIMEOUT-1; the mask is captured only on the first detection.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timer        <= '0;
      deadlock     <= 1'b0;
      blocked_mask <= '0;
    end else if (clr) begin
      timer        <= '0;
      deadlock     <= 1'b0;
      blocked_mask <= '0;
    end else if (progress || !window) begin
      timer <= '0;
    end else if (timer == TW'(TIMEOUT - 1)) begin
      if (!deadlock) begin
        deadlock     <= 1'b1;
        blocked_mask <= busy;
      end
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_PROC; i++)
      if (rd_proc == PW'(i)) rd_mux = pcnt[i][rd_sel];
    if (rd_proc == PW'(NUM_PROC)) begin
      if (rd_sel == RD_ITER)     rd_mux = top_iter;
      else if (rd_sel == RD_RUN) rd_mux = top_run;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_df_process_perf_monitor.sv
// Directed bench: shared stimulus into a 16-bit and a 4-bit (saturating) monitor instance.
module tb_df_process_perf_monitor;
  import df_mon_pkg::*;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        top_start, top_done, clr, rd_en;
  logic [3:0]  p_start, p_ready, p_done, p_continue;
  logic [2:0]  rd_proc;
  logic [1:0]  rd_sel;

  logic        rd_valid, window, deadlock;
  logic [15:0] rd_data;
  logic [3:0]  blocked_mask;
  logic        rd_valid_s, window_s, deadlock_s;
  logic [3:0]  rd_data_s;
  logic [3:0]  blocked_mask_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  df_process_perf_monitor #(.NUM_PROC(4), .CNT_W(16), .TIMEOUT(16)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .top_start(top_start), .top_done(top_done),
    .p_start(p_start), .p_ready(p_ready), .p_done(p_done), .p_continue(p_continue),
    .clr(clr), .rd_en(rd_en), .rd_proc(rd_proc), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .window(window), .deadlock(deadlock),
    .blocked_mask(blocked_mask)
  );

  df_process_perf_monitor #(.NUM_PROC(4), .CNT_W(4), .TIMEOUT(16)) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .top_start(top_start), .top_done(top_done),
    .p_start(p_start), .p_ready(p_ready), .p_done(p_done), .p_continue(p_continue),
    .clr(clr), .rd_en(rd_en), .rd_proc(rd_proc), .rd_sel(rd_sel),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .window(window_s), .deadlock(deadlock_s),
    .blocked_mask(blocked_mask_s)
  );

  typedef struct {
    logic [2:0]  proc;
    logic [1:0]  sel;
    logic [15:0] exp;
    logic [3:0]  exp_s;
  } rd_vec_t;

  rd_vec_t tbl [16];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] p, input logic [1:0] s, input logic [15:0] e,
                    input logic [3:0] es, input string nm);
    rd_en = 1'b1; rd_proc = p; rd_sel = s;
    tick();
    rd_en = 1'b0;
    chk({nm, " valid"}, 32'(rd_valid), 32'd1);
    chk(nm, 32'(rd_data), 32'(e));
    chk({nm, " sat"}, 32'(rd_data_s), 32'(es));
  endtask

  initial begin
    tbl[0]  = '{3'd0, RD_ITER,  16'd1,  4'd1};
    tbl[1]  = '{3'd0, RD_RUN,   16'd10, 4'd10};
    tbl[2]  = '{3'd0, RD_STALL, 16'd0,  4'd0};
    tbl[3]  = '{3'd0, RD_IDLE,  16'd8,  4'd8};
    tbl[4]  = '{3'd1, RD_ITER,  16'd1,  4'd1};
    tbl[5]  = '{3'd1, RD_RUN,   16'd2,  4'd2};
    tbl[6]  = '{3'd1, RD_STALL, 16'd5,  4'd5};
    tbl[7]  = '{3'd1, RD_IDLE,  16'd11, 4'd11};
    tbl[8]  = '{3'd2, RD_IDLE,  16'd18, 4'd15};
    tbl[9]  = '{3'd3, RD_RUN,   16'd0,  4'd0};
    tbl[10] = '{3'd4, RD_ITER,  16'd1,  4'd1};
    tbl[11] = '{3'd4, RD_STALL, 16'd0,  4'd0};
    tbl[12] = '{3'd4, RD_IDLE,  16'd0,  4'd0};
    tbl[13] = '{3'd5, RD_RUN,   16'd0,  4'd0};
    tbl[14] = '{3'd7, RD_ITER,  16'd0,  4'd0};
    tbl[15] = '{3'd4, RD_RUN,   16'd18, 4'd15};

    ap_rst_n = 1'b0; top_start = 0; top_done = 0; clr = 0; rd_en = 0;
    p_start = '0; p_ready = '0; p_done = '0; p_continue = '0; rd_proc = '0; rd_sel = '0;
    tick(); tick();
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset window", 32'(window), 32'd0);
    chk("reset deadlock", 32'(deadlock), 32'd0);
    chk("reset mask", 32'(blocked_mask), 32'd0);
    ap_rst_n = 1'b1;
    tick();

    // Single pass on p0, then an output stall on p1, then top done.
    top_start = 1; p_start = 4'b0001; tick(); top_start = 0; p_start = '0;
    chk("window set", 32'(window), 32'd1);
    repeat (8) tick();
    p_done = 4'b0001; p_continue = 4'b0001; tick(); p_done = '0; p_continue = '0;
    p_start = 4'b0010; tick(); p_start = '0;
    p_done = 4'b0010; tick(); p_done = '0;
    tick(); tick();
    rd(3'd1, RD_ITER, 16'd0, 4'd0, "p1 iter during stall");
    tick();
    chk("rd_valid drops", 32'(rd_valid), 32'd0);
    chk("rd_data holds", 32'(rd_data), 32'd0);
    p_continue = 4'b0010; tick(); p_continue = '0;
    chk("window still open", 32'(window), 32'd1);
    top_done = 1; tick(); top_done = 0;
    chk("window closed", 32'(window), 32'd0);
    repeat (3) tick();
    chk("no deadlock", 32'(deadlock), 32'd0);

    for (int i = 0; i < 16; i++)
      rd(tbl[i].proc, tbl[i].sel, tbl[i].exp, tbl[i].exp_s,
         $sformatf("tbl%0d p%0d s%0d", i, tbl[i].proc, tbl[i].sel));
    tick();
    chk("rd_data held after table", 32'(rd_data), 32'd18);

    // Two more short transactions: top iteration count reaches 3.
    for (int t = 0; t < 2; t++) begin
      top_start = 1; tick(); top_start = 0;
      top_done = 1; tick(); top_done = 0;
    end
    rd(3'd4, RD_ITER, 16'd3, 4'd3, "top iter x3");
    rd(3'd4, RD_RUN, 16'd22, 4'd15, "top run x3");

    // clr wins over the increment of the window set cycle.
    clr = 1; top_start = 1; tick(); clr = 0; top_start = 0;
    p_start = 4'b0100;
    rd(3'd4, RD_RUN, 16'd0, 4'd0, "top run after clr");
    p_start = '0;
    rd(3'd0, RD_ITER, 16'd0, 4'd0, "p0 iter after clr");
    repeat (13) tick();
    chk("deadlock before timeout", 32'(deadlock), 32'd0);
    tick();
    chk("deadlock at timeout", 32'(deadlock), 32'd1);
    chk("blocked mask", 32'(blocked_mask), 32'h4);
    chk("deadlock sat inst", 32'(deadlock_s), 32'd1);
    p_ready = 4'b0001; tick(); p_ready = '0;
    chk("deadlock sticky", 32'(deadlock), 32'd1);
    rd(3'd2, RD_RUN, 16'd17, 4'd15, "p2 run past deadlock");
    clr = 1; tick(); clr = 0;
    chk("deadlock cleared", 32'(deadlock), 32'd0);
    chk("mask cleared", 32'(blocked_mask), 32'd0);
    repeat (16) tick();
    chk("deadlock again", 32'(deadlock), 32'd1);

    // Asynchronous reset in the middle of an open window.
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async window", 32'(window), 32'd0);
    chk("async deadlock", 32'(deadlock), 32'd0);
    chk("async mask", 32'(blocked_mask), 32'd0);
    tick();
    ap_rst_n = 1'b1;
    repeat (3) tick();
    chk("no window w/o start", 32'(window), 32'd0);
    for (int p = 0; p <= 4; p++)
      rd(3'(p), RD_RUN, 16'd0, 4'd0, $sformatf("post-reset p%0d run", p));
    top_start = 1; tick(); top_start = 0;
    chk("fresh window", 32'(window), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
